// File: rtl/box_overlay_pkg.sv
// Shared ISP definitions for the box overlay: coordinate width, counter width
// and the frame-tracking FSM encoding.
package box_overlay_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned CNT_W   = 20;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/box_overlay_box_accum.sv
// Bounding-box accumulator: min/max/count of mask pixels over a frame, latched
// into the published box at each frame boundary.
module box_accum
  import box_overlay_pkg::*;
#(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned MIN_PIX = 64
) (
  input  logic   pixelclk,
  input  logic   rst_n,
  input  logic   acc_en,
  input  logic   latch,
  input  coord_t x,
  input  coord_t y,
  output logic   box_valid,
  output coord_t xmin,
  output coord_t xmax,
  output coord_t ymin,
  output coord_t ymax
);

  localparam coord_t X_LAST  = coord_t'(IMG_W - 1);
  localparam coord_t Y_LAST  = coord_t'(IMG_H - 1);
  localparam cnt_t   MIN_CNT = cnt_t'(MIN_PIX);
  localparam cnt_t   CNT_ONE = cnt_t'(1);

  coord_t acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  cnt_t   acc_cnt;
  logic   enough;

  assign enough = (acc_cnt >= MIN_CNT);

  // Latch wins over accumulate: a mask pixel on the boundary cycle is dropped.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_xmin  <= X_LAST;
      acc_xmax  <= '0;
      acc_ymin  <= Y_LAST;
      acc_ymax  <= '0;
      acc_cnt   <= '0;
      box_valid <= 1'b0;
      xmin      <= '0;
      xmax      <= '0;
      ymin      <= '0;
      ymax      <= '0;
    end else if (latch) begin
      box_valid <= enough;
      if (enough) begin
        xmin <= acc_xmin;
        xmax <= acc_xmax;
        ymin <= acc_ymin;
        ymax <= acc_ymax;
      end
      acc_xmin <= X_LAST;
      acc_xmax <= '0;
      acc_ymin <= Y_LAST;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (acc_en) begin
      if (x < acc_xmin) acc_xmin <= x;
      if (x > acc_xmax) acc_xmax <= x;
      if (y < acc_ymin) acc_ymin <= y;
      if (y > acc_ymax) acc_ymax <= y;
      if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/box_overlay.sv
// Draws the previous frame's mask bounding box onto the video stream with a
// fixed one-cycle latency.
module box_overlay
  import box_overlay_pkg::*;
#(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter int unsigned MIN_PIX   = 64
) (
  input  logic               pixelclk,
  input  logic               rst_n,
  input  logic               i_de,
  input  logic               i_vsync,
  input  logic               i_mask,
  input  logic [23:0]        i_rgb,
  output logic               o_de,
  output logic               o_vsync,
  output logic [23:0]        o_rgb,
  output logic               o_box_valid,
  output logic [COORD_W-1:0] o_xmin,
  output logic [COORD_W-1:0] o_xmax,
  output logic [COORD_W-1:0] o_ymin,
  output logic [COORD_W-1:0] o_ymax
);

  localparam coord_t X_LAST = coord_t'(IMG_W - 1);
  localparam coord_t Y_LAST = coord_t'(IMG_H - 1);
  localparam coord_t ONE    = coord_t'(1);

  state_t state, state_nxt;
  logic   de_d, vs_d;
  logic   vs_rise, de_fall;
  logic   latch, acc_en, border;
  coord_t x, y;

  assign vs_rise = i_vsync & ~vs_d;
  assign de_fall = de_d & ~i_de;
  assign o_de    = de_d;
  assign o_vsync = vs_d;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    acc_en    = 1'b0;
    unique case (state)
      ST_WAIT: if (vs_rise) state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        latch  = vs_rise;
        acc_en = i_de & i_mask;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (vs_rise) begin
      x <= '0;
      y <= '0;
    end else if (de_fall) begin
      x <= '0;
      if (y != Y_LAST) y <= y + ONE;
    end else if (i_de && (x != X_LAST)) begin
      x <= x + ONE;
    end
  end

  box_accum #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .MIN_PIX(MIN_PIX)
  ) u_accum (
    .pixelclk (pixelclk),
    .rst_n    (rst_n),
    .acc_en   (acc_en),
    .latch    (latch),
    .x        (x),
    .y        (y),
    .box_valid(o_box_valid),
    .xmin     (o_xmin),
    .xmax     (o_xmax),
    .ymin     (o_ymin),
    .ymax     (o_ymax)
  );

  always_comb begin
    border = 1'b0;
    if (o_box_valid && i_de) begin
      border = (((x == o_xmin) || (x == o_xmax)) && (y >= o_ymin) && (y <= o_ymax)) ||
               (((y == o_ymin) || (y == o_ymax)) && (x >= o_xmin) && (x <= o_xmax));
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      o_rgb <= '0;
      de_d  <= 1'b0;
      vs_d  <= 1'b0;
    end else begin
      o_rgb <= border ? BOX_COLOR : i_rgb;
      de_d  <= i_de;
      vs_d  <= i_vsync;
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
// Scoreboard bench for box_overlay: the driver queues per-cycle expectations,
// a monitor compares them one cycle later.
module tb_box_overlay;

  localparam int unsigned W = 160;
  localparam int unsigned H = 256;
  localparam logic [23:0] COLOR = 24'hFF0000;

  logic        pixelclk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        i_de     = 1'b0;
  logic        i_vsync  = 1'b0;
  logic        i_mask   = 1'b0;
  logic [23:0] i_rgb    = '0;
  logic        o_de, o_vsync, o_box_valid;
  logic [23:0] o_rgb;
  logic [10:0] o_xmin, o_xmax, o_ymin, o_ymax;

  box_overlay #(
    .IMG_W    (W),
    .IMG_H    (H),
    .BOX_COLOR(COLOR),
    .MIN_PIX  (64)
  ) dut (
    .pixelclk   (pixelclk),
    .rst_n      (rst_n),
    .i_de       (i_de),
    .i_vsync    (i_vsync),
    .i_mask     (i_mask),
    .i_rgb      (i_rgb),
    .o_de       (o_de),
    .o_vsync    (o_vsync),
    .o_rgb      (o_rgb),
    .o_box_valid(o_box_valid),
    .o_xmin     (o_xmin),
    .o_xmax     (o_xmax),
    .o_ymin     (o_ymin),
    .o_ymax     (o_ymax)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct {
    logic        de;
    logic        vs;
    logic [23:0] rgb;
    logic        bv;
    logic [10:0] x0, x1, y0, y1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        m_active, m_de, m_vs, m_bv;
  logic [10:0] m_x0, m_x1, m_y0, m_y1, bx, by;
  logic        nxt_v;
  logic [10:0] nxt_x0, nxt_x1, nxt_y0, nxt_y1;

  function automatic logic on_border(input logic [10:0] x, input logic [10:0] y);
    return m_bv && ((((x == m_x0) || (x == m_x1)) && (y >= m_y0) && (y <= m_y1)) ||
                    (((y == m_y0) || (y == m_y1)) && (x >= m_x0) && (x <= m_x1)));
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_de = 1'b0; m_vs = 1'b0; m_bv = 1'b0;
    m_x0 = '0; m_x1 = '0; m_y0 = '0; m_y1 = '0;
    bx = '0; by = '0;
  endtask

  task automatic cycle(input logic de, input logic vs, input logic mask, input logic [23:0] rgb);
    exp_t e;
    logic rise, fall;
    @(negedge pixelclk);
    i_de = de; i_vsync = vs; i_mask = mask; i_rgb = rgb;
    rise  = vs & ~m_vs;
    fall  = ~de & m_de;
    e.de  = de;
    e.vs  = vs;
    e.rgb = (de && on_border(bx, by)) ? COLOR : rgb;
    if (rise && m_active) begin
      m_bv = nxt_v;
      if (nxt_v) begin
        m_x0 = nxt_x0; m_x1 = nxt_x1; m_y0 = nxt_y0; m_y1 = nxt_y1;
      end
    end
    if (rise) m_active = 1'b1;
    if (rise) begin
      bx = '0; by = '0;
    end else if (fall) begin
      bx = '0;
      if (by < 11'(H - 1)) by = by + 11'd1;
    end else if (de && (bx < 11'(W - 1))) begin
      bx = bx + 11'd1;
    end
    m_de = de;
    m_vs = vs;
    e.bv = m_bv; e.x0 = m_x0; e.x1 = m_x1; e.y0 = m_y0; e.y1 = m_y1;
    q.push_back(e);
  endtask

  task automatic set_next(input logic v, input int x0, input int x1, input int y0, input int y1);
    nxt_v = v; nxt_x0 = 11'(x0); nxt_x1 = 11'(x1); nxt_y0 = 11'(y0); nxt_y1 = 11'(y1);
  endtask

  task automatic vsync(input logic v, input int x0, input int x1, input int y0, input int y1);
    set_next(v, x0, x1, y0, y1);
    cycle(1'b0, 1'b1, 1'b1, 24'hABCDEF);
    cycle(1'b0, 1'b1, 1'b0, 24'hABCDEF);
    cycle(1'b0, 1'b0, 1'b0, 24'h13579B);
  endtask

  // Lines below first_full are 2 pixels wide to keep frames short; each line
  // ends in one blanking cycle with mask held high.
  task automatic frame(input int nlines, input int first_full, input int npix,
                       input int mx0, input int mx1, input int my0, input int my1,
                       input logic pat, input logic [23:0] base, input logic mask_all);
    for (int l = 0; l < nlines; l++) begin
      int w;
      w = (l >= first_full) ? npix : 2;
      for (int p = 0; p < w; p++) begin
        logic m;
        logic [23:0] rgb;
        m   = mask_all || ((p >= mx0) && (p <= mx1) && (l >= my0) && (l <= my1));
        rgb = pat ? {base[23:16] ^ 8'(p), base[15:8] ^ 8'(l), base[7:0]} : base;
        cycle(1'b1, 1'b0, m, rgb);
      end
      cycle(1'b0, 1'b0, 1'b1, ~base);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    n_checks++;
    if ({o_rgb, o_de, o_vsync, o_box_valid, o_xmin, o_xmax, o_ymin, o_ymax} !== '0) begin
      n_errors++;
      $display("FAIL %s got rgb=%h de=%b vs=%b bv=%b box=%0d,%0d,%0d,%0d required all zero",
               tag, o_rgb, o_de, o_vsync, o_box_valid, o_xmin, o_xmax, o_ymin, o_ymax);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge pixelclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({o_de, o_vsync, o_rgb} !== {e.de, e.vs, e.rgb}) begin
          n_errors++;
          $display("FAIL pix t=%0t got de=%b vs=%b rgb=%h required de=%b vs=%b rgb=%h",
                   $time, o_de, o_vsync, o_rgb, e.de, e.vs, e.rgb);
        end
        n_checks++;
        if ({o_box_valid, o_xmin, o_xmax, o_ymin, o_ymax} !== {e.bv, e.x0, e.x1, e.y0, e.y1}) begin
          n_errors++;
          $display("FAIL box t=%0t got v=%b x=%0d..%0d y=%0d..%0d required v=%b x=%0d..%0d y=%0d..%0d",
                   $time, o_box_valid, o_xmin, o_xmax, o_ymin, o_ymax,
                   e.bv, e.x0, e.x1, e.y0, e.y1);
        end
      end
    end
  end

  initial begin
    set_next(1'b0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_reset_zero("reset_init");
    @(negedge pixelclk);
    rst_n = 1'b1;

    // No vsync yet: mask everywhere must not produce a box
    frame(3, 0, 20, 1, 0, 1, 0, 1'b1, 24'h5A5A5A, 1'b1);
    vsync(1'b0, 0, 0, 0, 0);

    // 50x40 box
    frame(240, 200, 150, 100, 149, 200, 239, 1'b1, 24'h102030, 1'b0);
    vsync(1'b1, 100, 149, 200, 239);

    // Draw it on green, no mask -> next latch invalid, corners held
    frame(242, 195, 155, 1, 0, 1, 0, 1'b0, 24'h00FF00, 1'b0);
    vsync(1'b0, 0, 0, 0, 0);

    // 63 pixels: invalid
    frame(9, 0, 40, 20, 28, 1, 7, 1'b0, 24'h00FF00, 1'b0);
    vsync(1'b0, 0, 0, 0, 0);

    // 64 pixels: valid
    frame(9, 0, 40, 20, 27, 0, 7, 1'b0, 24'h00FF00, 1'b0);
    vsync(1'b1, 20, 27, 0, 7);

    // Mask pixel on the vsync-rise cycle, frame continues straight on
    frame(9, 0, 40, 10, 19, 0, 7, 1'b1, 24'h445566, 1'b0);
    set_next(1'b1, 10, 19, 0, 7);
    cycle(1'b1, 1'b1, 1'b1, 24'h777777);
    frame(10, 0, 64, 50, 59, 2, 8, 1'b0, 24'h00FF00, 1'b0);
    vsync(1'b1, 50, 59, 2, 8);

    // Reset mid-frame
    frame(4, 0, 64, 1, 0, 1, 0, 1'b0, 24'h00FF00, 1'b1);
    for (int p = 0; p < 30; p++) cycle(1'b1, 1'b0, 1'b1, 24'h00FF00);
    @(negedge pixelclk);
    rst_n = 1'b0;
    #1;
    check_reset_zero("reset_mid");
    model_reset();
    repeat (2) @(negedge pixelclk);
    i_de = 1'b0; i_vsync = 1'b0; i_mask = 1'b0;
    rst_n = 1'b1;

    frame(3, 0, 20, 1, 0, 1, 0, 1'b1, 24'h202020, 1'b1);
    vsync(1'b0, 0, 0, 0, 0);
    frame(11, 0, 48, 30, 41, 3, 9, 1'b1, 24'h0A0B0C, 1'b0);
    vsync(1'b1, 30, 41, 3, 9);
    frame(11, 0, 48, 1, 0, 1, 0, 1'b0, 24'h00FF00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 24'h000000);
    cycle(1'b0, 1'b0, 1'b0, 24'h000000);

    repeat (3) @(posedge pixelclk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/box_overlay.md
BOX_OVERLAY -- requirements
Module: box_overlay

Interface
REQ-001 SHALL have parameter IMG_W, default 640: active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480: active lines per frame.
REQ-003 SHALL have parameter BOX_COLOR, default 24'hFF0000: overlay colour, {R,G,B}.
REQ-004 SHALL have parameter MIN_PIX, default 64: minimum mask-pixel count for a valid box.
REQ-005 SHALL have port pixelclk, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_de, input, 1 bit: active-video enable, aligned with i_rgb and i_mask.
REQ-008 SHALL have port i_vsync, input, 1 bit: frame sync, active-high.
REQ-009 SHALL have port i_mask, input, 1 bit: segmentation result, 1 = fruit pixel.
REQ-010 SHALL have port i_rgb, input, 24 bits: pixel from the upstream alignment delay line.
REQ-011 SHALL have ports o_de and o_vsync, output, 1 bit each: i_de and i_vsync delayed 1 cycle.
REQ-012 SHALL have port o_rgb, output, 24 bits: pixel with the box drawn on it.
REQ-013 SHALL have port o_box_valid, output, 1 bit: the latched box is valid.
REQ-014 SHALL have ports o_xmin, o_xmax, o_ymin, o_ymax, output, 11 bits each: latched box corners.

Function
REQ-015 SHALL detect the i_vsync rising edge (vs_rise) with a 1-cycle registered copy of i_vsync.
REQ-016 SHALL use a 2-state FSM: WAIT (after reset) -> ACTIVE on the first vs_rise; ACTIVE stays ACTIVE. In WAIT there is no accumulation, no latching, and o_box_valid=0.
REQ-017 SHALL use counter x: clears on vs_rise and on each i_de falling edge, increments per i_de=1 cycle, and saturates at IMG_W-1.
REQ-018 SHALL use counter y: clears on vs_rise, increments on each i_de falling edge, and saturates at IMG_H-1.
REQ-019 SHALL, in ACTIVE with i_de=1 and i_mask=1, update the accumulators acc_xmin/acc_xmax/acc_ymin/acc_ymax by min/max against (x,y); the mask-pixel count acc_cnt increments and saturates at 2^20-1. i_mask is ignored while i_de=0.
REQ-020 SHALL, on vs_rise in ACTIVE, latch the accumulators to the o_x*/o_y* outputs and set o_box_valid = (acc_cnt >= MIN_PIX). In the same cycle the accumulators reinitialise to xmin=IMG_W-1, xmax=0, ymin=IMG_H-1, ymax=0, cnt=0.
REQ-021 SHALL treat vs_rise as taking priority over a mask update in the same cycle: that pixel is dropped and is not counted in either frame.
REQ-022 SHALL hold o_x*/o_y* unchanged when o_box_valid=0 after latch; the overlay is then disabled.
REQ-023 SHALL define border = o_box_valid and i_de and ((x==o_xmin or x==o_xmax) and o_ymin<=y<=o_ymax, or (y==o_ymin or y==o_ymax) and o_xmin<=x<=o_xmax). The box drawn is therefore the previous frame's box.
REQ-024 SHALL register o_rgb = border ? BOX_COLOR : i_rgb, giving a latency of exactly 1 cycle from i_rgb/i_de/i_vsync to o_rgb/o_de/o_vsync.
REQ-025 SHALL pass o_rgb through unchanged from i_rgb when i_de=0.
REQ-026 SHALL make all comparisons unsigned, at 11 bits.

Reset
REQ-027 SHALL, when rst_n=0, clear asynchronously: o_rgb=0, o_de=0, o_vsync=0, o_box_valid=0, o_x*/o_y*=0, x=0, y=0, FSM=WAIT, accumulators at their reinitialise values.
REQ-028 SHALL treat assertion of reset mid-frame as discarding the partial frame; after release the block waits for the next vs_rise (WAIT state).

Structure
REQ-029 SHALL place the coordinate width (11) and the FSM state encoding in the shared ISP package.
REQ-030 SHALL put the min/max/count accumulation in one sub-module, box_accum; edge detection, counters and overlay mux stay in box_overlay.

Verification
REQ-031 SHALL cover: reset release with no vsync, mask=1 everywhere -> o_box_valid=0 and o_rgb equals i_rgb delayed 1 cycle.
REQ-032 SHALL cover: frame 1 with mask=1 on x 100..149, y 200..239 (2000 pixels), then vs_rise -> o_xmin=100, o_xmax=149, o_ymin=200, o_ymax=239, o_box_valid=1.
REQ-033 SHALL cover: frame 2 after REQ-032 with i_rgb=24'h00FF00 -> o_rgb=24'hFF0000 exactly at x=100 or 149 (y 200..239) and at y=200 or 239 (x 100..149); elsewhere 24'h00FF00.
REQ-034 SHALL cover: frame with 63 mask pixels -> o_box_valid=0 after vs_rise and no pixel recoloured in the next frame; the same test with 64 pixels -> o_box_valid=1.
REQ-035 SHALL cover: mask=1 on the same cycle as vs_rise -> that pixel is absent from both the latched box and the next frame's box.
REQ-036 SHALL cover: rst_n pulsed low mid-frame 2 -> all outputs 0 immediately; the next complete frame latches correct values.
